// File: rtl/booth_arith_pkg.sv
// Shared arithmetic definitions for the Booth multiplier and the sequential divider.
// Holds the FSM state encoding, the operand-width default and a wide negation helper.
package booth_arith_pkg;

  localparam int unsigned TamDefault = 16;
  localparam int unsigned NegMaxW    = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_e;

  // Caller sign-extends into NegMaxW bits; the extra MSB keeps the most negative value exact.
  function automatic logic [NegMaxW:0] neg_ext(input logic signed [NegMaxW-1:0] val);
    return -{val[NegMaxW-1], val};
  endfunction

endpackage

// File: rtl/booth_div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract the divisor, select.
module booth_div_step #(
  parameter int unsigned TAM = 16
) (
  input  logic [TAM-1:0] rem,
  input  logic [TAM-1:0] quo,
  input  logic [TAM-1:0] dmag,
  output logic [TAM-1:0] rem_next,
  output logic [TAM-1:0] quo_next
);

  logic [TAM:0]   shifted;
  logic [TAM+1:0] trial;
  logic           unused_trial;

  always_comb begin
    shifted = {rem, quo[TAM-1]};
    trial   = {1'b0, shifted} - {2'b00, dmag};
    if (!trial[TAM+1]) begin
      rem_next = trial[TAM-1:0];
      quo_next = {quo[TAM-2:0], 1'b1};
    end else begin
      rem_next = shifted[TAM-1:0];
      quo_next = {quo[TAM-2:0], 1'b0};
    end
  end

  // Bit TAM of a successful trial is zero whenever the quotient fits.
  assign unused_trial = trial[TAM];

endmodule

// File: rtl/booth_div_seq.sv
// Sequential signed divider: 2*TAM-bit dividend by TAM-bit divisor, one quotient bit per clock,
// truncating toward zero, with divide-by-zero and quotient-overflow flags.
module booth_div_seq
  import booth_arith_pkg::*;
#(
  parameter int unsigned TAM = TamDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2*TAM-1:0] N,
  input  logic [TAM-1:0]   D,
  output logic [TAM-1:0]   Q,
  output logic [TAM-1:0]   R,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  localparam int unsigned    CntW     = $clog2(TAM + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(TAM - 1);
  localparam logic [TAM-1:0]  MinMag   = {1'b1, {(TAM-1){1'b0}}};

  state_e          state;
  logic [CntW-1:0] count;
  logic [TAM-1:0]  rem, quo, dmag, n_lo;
  logic            sn, sd, dz_i, ovf_u;

  logic [NegMaxW:0]  n_neg, d_neg;
  logic [2*TAM-1:0]  n_mag;
  logic [TAM-1:0]    d_mag;
  logic              unused_neg;
  logic [TAM-1:0]    rem_nxt, quo_nxt;
  logic              q_neg, ovf_calc;
  logic [TAM-1:0]    q_signed, r_signed;

  assign n_neg      = neg_ext(NegMaxW'($signed(N)));
  assign d_neg      = neg_ext(NegMaxW'($signed(D)));
  assign n_mag      = N[2*TAM-1] ? n_neg[2*TAM-1:0] : N;
  assign d_mag      = D[TAM-1] ? d_neg[TAM-1:0] : D;
  assign unused_neg = ^{n_neg[NegMaxW:2*TAM], d_neg[NegMaxW:TAM]};

  booth_div_step #(
    .TAM(TAM)
  ) u_step (
    .rem     (rem),
    .quo     (quo),
    .dmag    (dmag),
    .rem_next(rem_nxt),
    .quo_next(quo_nxt)
  );

  // A negative quotient may reach magnitude 2^(TAM-1); a positive one may not.
  always_comb begin
    q_neg    = sn ^ sd;
    q_signed = q_neg ? -quo : quo;
    r_signed = sn ? -rem : rem;
    ovf_calc = ovf_u | (!q_neg & quo[TAM-1]) | (q_neg & (quo > MinMag));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      count <= '0;
      rem   <= '0;
      quo   <= '0;
      dmag  <= '0;
      n_lo  <= '0;
      sn    <= 1'b0;
      sd    <= 1'b0;
      dz_i  <= 1'b0;
      ovf_u <= 1'b0;
      Q     <= '0;
      R     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rem   <= n_mag[2*TAM-1:TAM];
            quo   <= n_mag[TAM-1:0];
            dmag  <= d_mag;
            n_lo  <= N[TAM-1:0];
            sn    <= N[2*TAM-1];
            sd    <= D[TAM-1];
            dz_i  <= (D == '0);
            ovf_u <= (n_mag[2*TAM-1:TAM] >= d_mag);
            count <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + 1'b1;
          if (count == LastStep) state <= SIGN;
        end
        SIGN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
          if (dz_i) begin
            Q   <= '1;
            R   <= n_lo;
            dz  <= 1'b1;
            ovf <= 1'b0;
          end else if (ovf_calc) begin
            Q   <= '1;
            R   <= '0;
            dz  <= 1'b0;
            ovf <= 1'b1;
          end else begin
            Q   <= q_signed;
            R   <= r_signed;
            dz  <= 1'b0;
            ovf <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_div_seq.sv
// Self-checking bench for booth_div_seq (TAM=16): directed cases, handshake corner cases
// and a random multiply/divide round trip against an integer-arithmetic reference model.
module tb_booth_div_seq;

  localparam int TAM = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [31:0]     N = '0;
  logic [15:0]     D = '0;
  logic [15:0]     Q, R;
  logic            busy, done, dz, ovf;

  int checks = 0;
  int errors = 0;

  booth_div_seq #(
    .TAM(TAM)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .N    (N),
    .D    (D),
    .Q    (Q),
    .R    (R),
    .busy (busy),
    .done (done),
    .dz   (dz),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer division, truncation toward zero, remainder takes the sign of N.
  task automatic model(input logic [31:0] n, input logic [15:0] d, output logic [15:0] q,
                       output logic [15:0] r, output logic edz, output logic eovf);
    longint sn, sd, qq, rr;
    sn = longint'($signed(n));
    sd = longint'($signed(d));
    if (sd == 0) begin
      q = '1; r = n[15:0]; edz = 1'b1; eovf = 1'b0;
    end else begin
      qq  = sn / sd;
      rr  = sn % sd;
      edz = 1'b0;
      if (qq > 32767 || qq < -32768) begin
        q = '1; r = '0; eovf = 1'b1;
      end else begin
        q = qq[15:0]; r = rr[15:0]; eovf = 1'b0;
      end
    end
  endtask

  task automatic run_div(input string tag, input logic [31:0] n, input logic [15:0] d,
                         input int pulse_at);
    logic [15:0] eq, er;
    logic        edz, eovf;
    int          lat, bcyc;
    model(n, d, eq, er, edz, eovf);
    @(negedge clk);
    N = n; D = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    bcyc  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      if (lat == pulse_at) begin
        N = ~n; D = d + 16'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (busy) bcyc++;
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd18);
    check({tag, "_busy_cycles"}, 32'(bcyc), 32'd17);
    check({tag, "_Q"}, 32'(Q), 32'(eq));
    check({tag, "_R"}, 32'(R), 32'(er));
    check({tag, "_dz"}, 32'(dz), 32'(edz));
    check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_idle_after"}, 32'(busy), 32'd0);
    check({tag, "_Q_hold"}, 32'(Q), 32'(eq));
  endtask

  initial begin
    logic [15:0] a, b;
    logic [31:0] p;
    logic        seen_done;

    repeat (2) @(negedge clk);
    check("reset_Q", 32'(Q), 32'd0);
    check("reset_R", 32'(R), 32'd0);
    check("reset_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    rst_n = 1'b1;

    run_div("pos_pos", 32'h0000_0064, 16'h0007, 0);
    run_div("neg_pos", 32'hFFFF_FF9C, 16'h0007, 0);
    run_div("neg_neg", 32'hFFFF_FF9C, 16'hFFF9, 0);
    run_div("div_zero", 32'h0000_0064, 16'h0000, 0);
    run_div("ovf_big", 32'h0001_0000, 16'h0001, 0);
    run_div("ovf_2p15", 32'h0000_8000, 16'h0001, 0);
    run_div("min_quot", 32'hFFFF_8000, 16'h0001, 0);
    run_div("zero_num", 32'h0000_0000, 16'hFFFD, 0);
    run_div("small_num", 32'hFFFF_FFFB, 16'h0009, 0);
    run_div("most_neg", 32'h8000_0000, 16'hFFFF, 0);
    run_div("ignored_start", 32'h0000_1234, 16'h0011, 5);

    // Reset in the middle of a division: outputs clear at once and no done follows.
    @(negedge clk);
    N = 32'h0000_0064; D = 16'h0007; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_Q", 32'(Q), 32'd0);
    check("abort_R", 32'(R), 32'd0);
    check("abort_flags", {28'd0, busy, done, dz, ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 32'(seen_done), 32'd0);
    run_div("after_abort", 32'h0000_0064, 16'h0007, 0);

    run_div("rt_edge", 32'h0000_8000, 16'hFFFF, 0);
    for (int i = 0; i < 16; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (b == '0) b = 16'h0001;
      p = 32'($signed(a) * $signed(b));
      run_div("rt_rand", p, b, 0);
    end
    for (int i = 0; i < 6; i++) begin
      p = 32'($signed(20'($urandom)));
      b = 16'($urandom);
      run_div("gen_rand", p, b, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
